// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM stage slice.
// Holds the load-op encodings, the MEM FSM state type and helpers that
// derive the EXE->MEM, MEM->WB and MEM->ID bus widths from the datapath
// parameters, so that every file computes the same bus layout.
package pipe_pkg;

  // Load extension selector carried in the EXE->MEM bus; codes 5..7 act as LW.
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY,  // nothing held
    ST_WAIT,   // instruction held, SRAM response still owed
    ST_READY,  // instruction held, result complete
    ST_DROP    // instruction flushed, its response still owed
  } ms_state_e;

  // Control prefix of the EXE->MEM bus: ld_op(3) addr_lo(2) res_from_mem wait_mem gr_we
  localparam int ES_CTRL_W = 8;

  function automatic int es_bus_w(input int data_w, input int pc_w, input int reg_aw);
    return ES_CTRL_W + reg_aw + data_w + pc_w;
  endfunction

  function automatic int ws_bus_w(input int data_w, input int pc_w, input int reg_aw);
    return 1 + reg_aw + data_w + pc_w;
  endfunction

  function automatic int fwd_bus_w(input int data_w, input int reg_aw);
    return 1 + reg_aw + data_w;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Handshake and bus bundle around the MEM stage.
// master: the surroundings (EXE, WB, data SRAM, flush source, ID).
// slave : the MEM stage itself.
// Signals: es_to_ms_valid/es_to_ms_bus/ms_allowin (EXE side),
// ms_to_ws_valid/ms_to_ws_bus/ws_allowin (WB side),
// data_sram_data_ok/data_sram_rdata (SRAM response), ms_flush,
// ms_fwd_bus/ms_fwd_stall (to ID).
interface mem_stage_lsu_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_AW = 5
);
  import pipe_pkg::*;

  localparam int ES_BUS_W  = es_bus_w(DATA_W, PC_W, REG_AW);
  localparam int WS_BUS_W  = ws_bus_w(DATA_W, PC_W, REG_AW);
  localparam int FWD_BUS_W = fwd_bus_w(DATA_W, REG_AW);

  logic                  es_to_ms_valid;
  logic [ES_BUS_W-1:0]   es_to_ms_bus;
  logic                  ms_allowin;
  logic                  ws_allowin;
  logic                  ms_to_ws_valid;
  logic [WS_BUS_W-1:0]   ms_to_ws_bus;
  logic                  data_sram_data_ok;
  logic [DATA_W-1:0]     data_sram_rdata;
  logic                  ms_flush;
  logic [FWD_BUS_W-1:0]  ms_fwd_bus;
  logic                  ms_fwd_stall;

  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin,
           data_sram_data_ok, data_sram_rdata, ms_flush,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_fwd_stall
  );

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
           data_sram_data_ok, data_sram_rdata, ms_flush,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_fwd_stall
  );

endinterface

// File: rtl/load_align.sv
// Combinational load data aligner.
// Ports: ld_op (load kind), addr_lo (byte offset in the word),
// raw (word returned by memory), result (sign/zero extended, DATA_W wide).
module load_align
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        ld_op,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Shift the addressed lane down to bit 0; halfwords only look at addr_lo[1].
  assign sel_byte = 8'(raw >> {addr_lo, 3'b000});
  assign sel_half = 16'(raw >> {addr_lo[1], 4'b0000});

  always_comb begin
    result = raw;
    case (ld_op)
      LD_B:    result = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
      LD_BU:   result = {{(DATA_W-8){1'b0}}, sel_byte};
      LD_H:    result = {{(DATA_W-16){sel_half[15]}}, sel_half};
      LD_HU:   result = {{(DATA_W-16){1'b0}}, sel_half};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with variable-latency data SRAM response.
// Ports: clk, resetn (synchronous, active low), lsu (slave side of
// mem_stage_lsu_if: EXE input handshake, WB output handshake, SRAM
// response, flush, forwarding to ID).
// Holds one instruction; waits for data_ok when the instruction issued a
// memory request, parks the response in a skid register while WB stalls,
// and swallows the response of a flushed instruction.
module mem_stage_lsu
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_AW = 5
) (
  input  logic             clk,
  input  logic             resetn,
  mem_stage_lsu_if.slave   lsu
);

  localparam int ES_BUS_W = es_bus_w(DATA_W, PC_W, REG_AW);
  localparam int OFS_ALU  = PC_W;
  localparam int OFS_DEST = OFS_ALU + DATA_W;
  localparam int OFS_GWE  = OFS_DEST + REG_AW;
  localparam int OFS_WAIT = OFS_GWE + 1;
  localparam int OFS_RFM  = OFS_GWE + 2;
  localparam int OFS_LO   = OFS_GWE + 3;
  localparam int OFS_OP   = OFS_GWE + 5;

  ms_state_e           state_reg;
  logic [ES_BUS_W-1:0] bus_reg;
  logic [DATA_W-1:0]   skid_reg;

  // Fields of the held instruction
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] alu_result;
  logic [REG_AW-1:0] dest;
  logic              gr_we;
  logic              res_from_mem;
  logic [1:0]        addr_lo;
  logic [2:0]        ld_op;
  logic              unused_wait_mem;

  assign pc              = bus_reg[PC_W-1:0];
  assign alu_result      = bus_reg[OFS_ALU +: DATA_W];
  assign dest            = bus_reg[OFS_DEST +: REG_AW];
  assign gr_we           = bus_reg[OFS_GWE];
  assign res_from_mem    = bus_reg[OFS_RFM];
  assign addr_lo         = bus_reg[OFS_LO +: 2];
  assign ld_op           = bus_reg[OFS_OP +: 3];
  assign unused_wait_mem = bus_reg[OFS_WAIT];

  logic              data_ok;
  logic              ms_valid;
  logic              ms_ready_go;
  logic              to_ws_valid;
  logic              handoff;
  logic              allowin;
  logic              accept;
  ms_state_e         refill_state;
  logic [DATA_W-1:0] load_raw;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] final_result;

  assign data_ok      = lsu.data_sram_data_ok;
  assign ms_valid     = (state_reg == ST_WAIT) || (state_reg == ST_READY);
  assign ms_ready_go  = (state_reg == ST_READY) || (state_reg == ST_WAIT && data_ok);
  assign to_ws_valid  = ms_valid && ms_ready_go && !lsu.ms_flush;
  assign handoff      = to_ws_valid && lsu.ws_allowin;
  // handoff already excludes a flush cycle, so the refill term needs no extra gating
  assign allowin      = (state_reg == ST_EMPTY && !lsu.ms_flush) || handoff;
  assign accept       = lsu.es_to_ms_valid && allowin;
  assign refill_state = lsu.es_to_ms_bus[OFS_WAIT] ? ST_WAIT : ST_READY;

  // Live response in its arrival cycle, otherwise the parked copy
  assign load_raw = (state_reg == ST_WAIT) ? lsu.data_sram_rdata : skid_reg;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .ld_op   (ld_op),
    .addr_lo (addr_lo),
    .raw     (load_raw),
    .result  (load_ext)
  );

  assign final_result = res_from_mem ? load_ext : alu_result;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= ST_EMPTY;
      bus_reg   <= '0;
      skid_reg  <= '0;
    end else begin
      if (accept) begin
        bus_reg <= lsu.es_to_ms_bus;
      end
      if (state_reg == ST_WAIT && data_ok && !lsu.ws_allowin && !lsu.ms_flush) begin
        skid_reg <= lsu.data_sram_rdata;
      end
      case (state_reg)
        ST_EMPTY: begin
          if (accept) state_reg <= refill_state;
        end
        ST_WAIT: begin
          if (lsu.ms_flush) begin
            // A response arriving with the flush is consumed right here
            state_reg <= data_ok ? ST_EMPTY : ST_DROP;
          end else if (data_ok) begin
            if (handoff) state_reg <= accept ? refill_state : ST_EMPTY;
            else         state_reg <= ST_READY;
          end
        end
        ST_READY: begin
          if (lsu.ms_flush)  state_reg <= ST_EMPTY;
          else if (handoff)  state_reg <= accept ? refill_state : ST_EMPTY;
        end
        ST_DROP: begin
          if (data_ok) state_reg <= ST_EMPTY;
        end
        default: state_reg <= ST_EMPTY;
      endcase
    end
  end

  assign lsu.ms_allowin     = allowin;
  assign lsu.ms_to_ws_valid = to_ws_valid;
  assign lsu.ms_to_ws_bus   = {gr_we, dest, final_result, pc};
  assign lsu.ms_fwd_bus     = {ms_valid && gr_we, dest, final_result};
  // Combinational so ID can take rdata through the forward bus in the data_ok cycle
  assign lsu.ms_fwd_stall   = (state_reg == ST_WAIT) && res_from_mem && !data_ok;

  // A response with no request owed means the SRAM side broke the protocol
  a_no_stray_data_ok: assert property (@(posedge clk) disable iff (!resetn)
    !(data_ok && (state_reg == ST_EMPTY || state_reg == ST_READY)));

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized self-checking bench for mem_stage_lsu against a
// transaction-level model of the stage (held instruction + orphan response).
module tb_mem_stage_lsu;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_stage_lsu_if #(.DATA_W(32), .PC_W(32), .REG_AW(5)) lsu();

  mem_stage_lsu #(.DATA_W(32), .PC_W(32), .REG_AW(5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .lsu    (lsu)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model state: the instruction held by MEM, if any
  logic        m_held = 1'b0, m_wait = 1'b0, m_drop = 1'b0;
  logic [2:0]  m_op = '0;
  logic [1:0]  m_lo = '0;
  logic        m_rfm = 1'b0, m_gwe = 1'b0;
  logic [4:0]  m_dst = '0;
  logic [31:0] m_alu = '0, m_pc = '0, m_data = '0;
  // SRAM side: one response owed, and cycles since its request entered MEM
  logic        owed = 1'b0;
  int          age = 0;
  // Last observed values, for directed constant checks
  logic [31:0] obs_res;
  logic        obs_valid, obs_stall, obs_allow;

  function automatic logic [31:0] ext(input logic [2:0] op, input logic [1:0] lo, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * lo)) & 32'hFF;
    h = (d >> (16 * lo[1])) & 32'hFFFF;
    case (op)
      3'd1:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return d;
    endcase
  endfunction

  task automatic step(input logic v, input logic [2:0] op, input logic [1:0] lo,
                      input logic rfm, input logic wm, input logic gwe, input logic [4:0] dst,
                      input logic [31:0] alu, input logic [31:0] pc, input logic wsa,
                      input logic dok, input logic [31:0] rd, input logic fl);
    logic e_go, e_valid, e_allow, e_stall, e_fwdv;
    logic [31:0] e_res;
    @(negedge clk);
    lsu.es_to_ms_valid    = v;
    lsu.es_to_ms_bus      = {op, lo, rfm, wm, gwe, dst, alu, pc};
    lsu.ws_allowin        = wsa;
    lsu.data_sram_data_ok = dok;
    lsu.data_sram_rdata   = rd;
    lsu.ms_flush          = fl;
    #1;
    e_go    = m_held && (!m_wait || dok);
    e_valid = e_go && !fl;
    e_allow = !fl && !m_drop && (!m_held || (e_valid && wsa));
    e_stall = m_held && m_wait && m_rfm && !dok;
    e_fwdv  = m_held && m_gwe;
    e_res   = m_rfm ? ext(m_op, m_lo, m_wait ? rd : m_data) : m_alu;
    obs_res   = lsu.ms_to_ws_bus[63:32];
    obs_valid = lsu.ms_to_ws_valid;
    obs_stall = lsu.ms_fwd_stall;
    obs_allow = lsu.ms_allowin;
    check_eq("to_ws_valid", 128'(lsu.ms_to_ws_valid), 128'(e_valid));
    check_eq("allowin", 128'(lsu.ms_allowin), 128'(e_allow));
    check_eq("fwd_stall", 128'(lsu.ms_fwd_stall), 128'(e_stall));
    check_eq("fwd_valid", 128'(lsu.ms_fwd_bus[37]), 128'(e_fwdv));
    if (e_valid) begin
      check_eq("ws_bus", 128'(lsu.ms_to_ws_bus), 128'({m_gwe, m_dst, e_res, m_pc}));
      if (wsa) $display("xfer pc=%08h dest=%0d we=%0b result=%08h", m_pc, m_dst, m_gwe, e_res);
    end
    if (e_fwdv && !e_stall)
      check_eq("fwd_bus", 128'(lsu.ms_fwd_bus[36:0]), 128'({m_dst, e_res}));
    @(posedge clk);
    if (m_drop) begin
      if (dok) m_drop = 1'b0;
    end else if (m_held) begin
      if (fl) begin
        if (m_wait && !dok) m_drop = 1'b1;
        m_held = 1'b0;
      end else begin
        if (m_wait && dok) begin
          m_wait = 1'b0;
          m_data = rd;
        end
        if (e_valid && wsa) m_held = 1'b0;
      end
    end
    if (v && e_allow) begin
      m_held = 1'b1; m_wait = wm; m_op = op; m_lo = lo; m_rfm = rfm;
      m_gwe = gwe; m_dst = dst; m_alu = alu; m_pc = pc;
    end
    if (dok) owed = 1'b0;
    else if (owed) age++;
    if (v && e_allow && wm) begin
      owed = 1'b1;
      age = 0;
    end
  endtask

  task automatic idle(input logic wsa, input logic dok, input logic [31:0] rd, input logic fl);
    step(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, wsa, dok, rd, fl);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 128'(lsu.ms_to_ws_valid), 128'(1'b0));
    check_eq({tag, "_allowin"}, 128'(lsu.ms_allowin), 128'(1'b1));
    check_eq({tag, "_stall"}, 128'(lsu.ms_fwd_stall), 128'(1'b0));
    check_eq({tag, "_fwdv"}, 128'(lsu.ms_fwd_bus[37]), 128'(1'b0));
  endtask

  initial begin
    lsu.es_to_ms_valid = 1'b0; lsu.es_to_ms_bus = '0; lsu.ws_allowin = 1'b1;
    lsu.data_sram_data_ok = 1'b0; lsu.data_sram_rdata = '0; lsu.ms_flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;

    // ALU op, one cycle in MEM
    step(1, 3'd0, 2'd0, 0, 0, 1, 5'd3, 32'h1234_5678, 32'h100, 1, 0, 0, 0);
    idle(1, 0, 0, 0);
    check_eq("alu_valid", 128'(obs_valid), 128'(1'b1));
    check_eq("alu_result", 128'(obs_res), 128'(32'h1234_5678));

    // LB at offset 3, response two cycles after entry
    step(1, 3'd1, 2'd3, 1, 1, 1, 5'd5, 32'h0, 32'h104, 1, 0, 0, 0);
    idle(1, 0, 0, 0);
    check_eq("lb_stall1", 128'(obs_stall), 128'(1'b1));
    idle(1, 0, 0, 0);
    check_eq("lb_stall2", 128'(obs_stall), 128'(1'b1));
    idle(1, 1, 32'h80FF_0011, 0);
    check_eq("lb_result", 128'(obs_res), 128'(32'hFFFF_FF80));

    // LHU at offset 2
    step(1, 3'd4, 2'd2, 1, 1, 1, 5'd6, 32'h0, 32'h108, 1, 0, 0, 0);
    idle(1, 0, 0, 0);
    idle(1, 1, 32'h80FF_0011, 0);
    check_eq("lhu_result", 128'(obs_res), 128'(32'h0000_80FF));

    // LW whose response arrives while WB stalls
    step(1, 3'd0, 2'd0, 1, 1, 1, 5'd7, 32'h0, 32'h10C, 1, 0, 0, 0);
    idle(1, 0, 0, 0);
    idle(0, 1, 32'hDEAD_BEEF, 0);
    idle(0, 0, 0, 0);
    idle(0, 0, 0, 0);
    idle(1, 0, 0, 0);
    check_eq("lw_skid_result", 128'(obs_res), 128'(32'hDEAD_BEEF));

    // Flush while waiting, orphan response dropped, next load gets its own
    step(1, 3'd0, 2'd0, 1, 1, 1, 5'd8, 32'h0, 32'h110, 1, 0, 0, 0);
    idle(1, 0, 0, 1);
    idle(1, 0, 0, 0);
    check_eq("drop_allowin", 128'(obs_allow), 128'(1'b0));
    idle(1, 1, 32'hAAAA_AAAA, 0);
    check_eq("drop_no_valid", 128'(obs_valid), 128'(1'b0));
    step(1, 3'd0, 2'd0, 1, 1, 1, 5'd9, 32'h0, 32'h114, 1, 0, 0, 0);
    check_eq("after_drop_allowin", 128'(obs_allow), 128'(1'b1));
    idle(1, 0, 0, 0);
    idle(1, 1, 32'h1122_3344, 0);
    check_eq("post_drop_result", 128'(obs_res), 128'(32'h1122_3344));

    // Back-to-back ALU ops
    for (int i = 0; i < 4; i++) begin
      step(1, 3'd0, 2'd0, 0, 0, 1, 5'(10 + i), 32'(1000 + i), 32'(32'h200 + 4 * i), 1, 0, 0, 0);
      check_eq("b2b_allowin", 128'(obs_allow), 128'(1'b1));
    end
    idle(1, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      logic v, wm, rfm, dok, wsa, fl;
      v   = ($urandom_range(0, 3) != 0);
      wm  = owed ? 1'b0 : 1'($urandom_range(0, 1));
      rfm = wm && ($urandom_range(0, 3) != 0);
      dok = owed && (age >= 1) && ($urandom_range(0, 2) == 0);
      wsa = ($urandom_range(0, 9) < 7);
      fl  = ($urandom_range(0, 9) == 0);
      step(v, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), rfm, wm,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom,
           wsa, dok, $urandom, fl);
    end

    // Drain, then reset while an instruction sits in READY
    for (int n = 0; n < 20 && (m_held || m_drop); n++)
      idle(1, owed && (age >= 1), $urandom, 0);
    check_eq("drain_done", 128'(m_held || m_drop), 128'(1'b0));
    step(1, 3'd0, 2'd0, 0, 0, 1, 5'd2, 32'h5555_0000, 32'h300, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    check_eq("ready_before_reset", 128'(obs_valid), 128'(1'b1));
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    check_reset_outputs("mid_reset");
    m_held = 1'b0; m_wait = 1'b0; m_drop = 1'b0; owed = 1'b0;
    step(1, 3'd0, 2'd0, 0, 0, 1, 5'd4, 32'hCAFE_0001, 32'h304, 1, 0, 0, 0);
    idle(1, 0, 0, 0);
    check_eq("post_reset_result", 128'(obs_res), 128'(32'hCAFE_0001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
